// File: rtl/uart_pkg.sv
// Shared UART definitions: 16x-oversampling divisor table and frame state encoding.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  // Cycles per 16x tick at 100 MHz, indexed by baud_select (300 .. 115200 baud).
  localparam logic [15:0] BAUD_DIVISOR [8] = '{
    16'd20833, 16'd5208, 16'd1302, 16'd651,
    16'd325,   16'd162,  16'd108,  16'd54
  };

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

endpackage

// File: rtl/uart_tx_baud_gen.sv
// 16x tick generator: divisor lookup plus a free-running counter that emits a
// one-cycle tick every max_value cycles while enabled.
module uart_tx_baud_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       Tx_EN,
  input  logic [2:0] baud_select,
  output logic       tick
);
  import uart_pkg::*;

  logic [15:0] count;
  logic [15:0] max_value;
  logic [2:0]  baud_prev;
  logic        rate_change;

  assign max_value   = BAUD_DIVISOR[baud_select];
  assign rate_change = (baud_select != baud_prev);
  // A rate change restarts the period instead of finishing one at the old rate.
  assign tick        = Tx_EN && !rate_change && (count == max_value - 16'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      baud_prev <= '0;
    end else begin
      baud_prev <= baud_select;
      if (!Tx_EN || rate_change || tick) begin
        count <= '0;
      end else begin
        count <= count + 16'd1;
      end
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB first, stop bit, each 16 ticks long.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_transmitter #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       TxD,
  output logic       Tx_BUSY
);
  import uart_pkg::*;

  if (OVERSAMPLE != uart_pkg::OVERSAMPLE) begin : g_oversample_check
    $error("uart_transmitter: divisor table is only valid for OVERSAMPLE=16");
  end
  if (CLK_HZ != 100_000_000) begin : g_clk_check
    $warning("uart_transmitter: divisor table assumes a 100 MHz clock");
  end

`ifdef UART_TX_PARITY_EN
  localparam uart_state_t AFTER_DATA = PARITY;
`else
  localparam uart_state_t AFTER_DATA = STOP;
`endif

  uart_state_t state, state_next;
  logic [2:0]  bit_index, bit_index_next;
  logic [3:0]  tick_count, tick_count_next;
  logic [7:0]  data_reg, data_next;
  logic        txd_next;
  logic        busy_next;
  logic        tick;
  logic        bit_done;
  logic        gen_en;

  // Holding the generator disabled for the accept cycle restarts its period
  // exactly at the start-bit edge.
  assign gen_en   = Tx_EN && !(Tx_WR && state == IDLE);
  assign bit_done = tick && (tick_count == 4'(OVERSAMPLE - 1));

  uart_tx_baud_gen u_baud_gen (
    .clk         (clk),
    .reset       (reset),
    .Tx_EN       (gen_en),
    .baud_select (baud_select),
    .tick        (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bit_index  <= '0;
      tick_count <= '0;
      data_reg   <= '0;
      TxD        <= 1'b1;
      Tx_BUSY    <= 1'b0;
    end else begin
      state      <= state_next;
      bit_index  <= bit_index_next;
      tick_count <= tick_count_next;
      data_reg   <= data_next;
      TxD        <= txd_next;
      Tx_BUSY    <= busy_next;
    end
  end

  always_comb begin
    state_next      = state;
    bit_index_next  = bit_index;
    tick_count_next = tick_count;
    data_next       = data_reg;

    if (!Tx_EN) begin
      state_next      = IDLE;
      bit_index_next  = '0;
      tick_count_next = '0;
    end else begin
      if (state != IDLE && tick) begin
        tick_count_next = tick_count + 4'd1;
      end
      case (state)
        IDLE: begin
          if (Tx_WR) begin
            state_next      = START;
            data_next       = Tx_DATA;
            bit_index_next  = '0;
            tick_count_next = '0;
          end
        end
        START: begin
          if (bit_done) state_next = DATA;
        end
        DATA: begin
          if (bit_done) begin
            bit_index_next = bit_index + 3'd1;
            if (bit_index == 3'd7) state_next = AFTER_DATA;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) state_next = STOP;
        end
`endif
        STOP: begin
          if (bit_done) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end

    // Outputs are registered from the next state so TxD/Tx_BUSY switch on the
    // same edge as the state itself.
    txd_next = 1'b1;
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = data_next[bit_index_next];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_next = ^data_next;
`endif
      default: txd_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: elapsed-cycle frame model checked every cycle,
// plus hand-computed bit patterns, boundaries, abort, reset and rate pins.
`timescale 1ns/1ps
module tb_uart_transmitter;

  localparam int DIV_TABLE [8] = '{20833, 5208, 1302, 651, 325, 162, 108, 54};
  localparam int BIT_SEL7 = 864;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam int FRAME_SEL7 = 9504;
  localparam logic [10:0] LIT_A5 = 11'b1_0_10100101_0;
  localparam logic [10:0] LIT_07 = 11'b1_1_00000111_0;
  localparam logic [10:0] LIT_00 = 11'b1_0_00000000_0;
  localparam logic [10:0] LIT_55 = 11'b1_0_01010101_0;
  localparam logic [10:0] LIT_AA = 11'b1_0_10101010_0;
`else
  localparam int NBITS = 10;
  localparam int FRAME_SEL7 = 8640;
  localparam logic [10:0] LIT_A5 = 11'b1_1_10100101_0;
  localparam logic [10:0] LIT_07 = 11'b1_1_00000111_0;
  localparam logic [10:0] LIT_00 = 11'b1_1_00000000_0;
  localparam logic [10:0] LIT_55 = 11'b1_1_01010101_0;
  localparam logic [10:0] LIT_AA = 11'b1_1_10101010_0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] baud_select = 3'd7;
  logic       Tx_EN = 1'b0;
  logic       Tx_WR = 1'b0;
  logic [7:0] Tx_DATA = 8'h00;
  logic       TxD;
  logic       Tx_BUSY;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  uart_transmitter dut (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_select),
    .Tx_EN       (Tx_EN),
    .Tx_WR       (Tx_WR),
    .Tx_DATA     (Tx_DATA),
    .TxD         (TxD),
    .Tx_BUSY     (Tx_BUSY)
  );

  task automatic check_bit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_int(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Frame model: once a byte is accepted the line is simply bit[elapsed / bit_len]
  // of the frame vector until NBITS whole bits have elapsed.
  logic        m_active = 1'b0;
  int          m_elapsed = 0;
  logic [10:0] m_frame = '1;

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
    if (NBITS == 11) f[9] = ^d;
    return f;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
    end else if (!Tx_EN) begin
      m_active <= 1'b0;
    end else if (m_active) begin
      if (m_elapsed + 1 == NBITS * 16 * DIV_TABLE[baud_select]) m_active <= 1'b0;
      m_elapsed <= m_elapsed + 1;
    end else if (Tx_WR) begin
      m_active  <= 1'b1;
      m_elapsed <= 0;
      m_frame   <= frame_of(Tx_DATA);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check_bit("busy_model", Tx_BUSY, m_active);
      check_bit("txd_model", TxD,
                m_active ? m_frame[m_elapsed / (16 * DIV_TABLE[baud_select])] : 1'b1);
    end
  end

  task automatic advance_to(inout int cur, input int target);
    if (target > cur) begin
      repeat (target - cur) @(posedge clk);
      #1;
      cur = target;
    end
  endtask

  // Sends d at baud_select=7, pins every bit mid-period and the frame end;
  // optionally fires an extra write while busy after bit inject_bit.
  task automatic run_frame(input string name, input logic [7:0] d,
                           input logic [10:0] lit, input int inject_bit);
    int cur;
    @(negedge clk);
    Tx_DATA = d;
    Tx_WR   = 1'b1;
    @(posedge clk);
    #1;
    Tx_WR   = 1'b0;
    Tx_DATA = ~d;
    cur = 0;
    check_bit({name, "_start_now"}, TxD, 1'b0);
    check_bit({name, "_busy_now"}, Tx_BUSY, 1'b1);
    for (int i = 0; i < NBITS; i++) begin
      advance_to(cur, i * BIT_SEL7 + BIT_SEL7 / 2);
      check_bit($sformatf("%s_bit%0d", name, i), TxD, lit[i]);
      if (i == inject_bit) begin
        @(negedge clk);
        Tx_DATA = 8'hFF;
        Tx_WR   = 1'b1;
        @(posedge clk);
        #1;
        Tx_WR = 1'b0;
        cur++;
      end
    end
    advance_to(cur, FRAME_SEL7 - 1);
    check_bit({name, "_busy_last"}, Tx_BUSY, 1'b1);
    advance_to(cur, FRAME_SEL7);
    check_bit({name, "_busy_fall"}, Tx_BUSY, 1'b0);
    check_bit({name, "_line_idle"}, TxD, 1'b1);
  endtask

  // Counts cycles from a rate change to the first tick (the change restarts the period).
  task automatic measure_period(input logic [2:0] sel, input string name, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    @(negedge clk);
    baud_select = sel;
    for (int i = 0; i < 25000 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (dut.u_baud_gen.tick === 1'b1) seen = 1'b1;
    end
    if (!seen) check_bit({name, "_tick_seen"}, 1'b0, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #23;
    check_bit("reset_txd", TxD, 1'b1);
    check_bit("reset_busy", Tx_BUSY, 1'b0);
    @(negedge clk);
    reset    = 1'b1;
    Tx_EN    = 1'b1;
    check_en = 1'b1;
    repeat (100) @(posedge clk);
    #1;

    // Basic frame with a write while busy that must be dropped.
    run_frame("a5", 8'hA5, LIT_A5, 5);
    repeat (2000) @(posedge clk);
    #1;
    check_bit("no_queued_frame_busy", Tx_BUSY, 1'b0);
    check_bit("no_queued_frame_txd", TxD, 1'b1);

    run_frame("x07", 8'h07, LIT_07, -1);
    repeat (20) @(posedge clk);
    #1;
    run_frame("x00", 8'h00, LIT_00, -1);
    repeat (20) @(posedge clk);
    #1;

    // Back-to-back: second write lands on the first IDLE edge.
    run_frame("x55", 8'h55, LIT_55, -1);
    run_frame("xaa", 8'hAA, LIT_AA, -1);
    repeat (50) @(posedge clk);
    #1;

    // Abort by dropping Tx_EN during data bit 1 (a zero) of 0x3C.
    @(negedge clk);
    Tx_DATA = 8'h3C;
    Tx_WR   = 1'b1;
    @(posedge clk);
    #1;
    Tx_WR = 1'b0;
    repeat (2 * BIT_SEL7 + 100) @(posedge clk);
    #1;
    check_bit("abort_txd_before", TxD, 1'b0);
    check_bit("abort_busy_before", Tx_BUSY, 1'b1);
    Tx_EN = 1'b0;
    @(posedge clk);
    #1;
    check_bit("abort_txd", TxD, 1'b1);
    check_bit("abort_busy", Tx_BUSY, 1'b0);
    repeat (200) @(posedge clk);
    #1;
    Tx_EN = 1'b1;
    repeat (100) @(posedge clk);
    #1;

    // Asynchronous reset during data bit 3 (a zero) of 0x96.
    @(negedge clk);
    Tx_DATA = 8'h96;
    Tx_WR   = 1'b1;
    @(posedge clk);
    #1;
    Tx_WR = 1'b0;
    repeat (4 * BIT_SEL7 + 300) @(posedge clk);
    #2;
    check_bit("rst_txd_before", TxD, 1'b0);
    reset = 1'b0;
    #1;
    check_bit("rst_txd_async", TxD, 1'b1);
    check_bit("rst_busy_async", Tx_BUSY, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (1500) @(posedge clk);
    #1;
    check_bit("post_reset_busy", Tx_BUSY, 1'b0);
    check_bit("post_reset_txd", TxD, 1'b1);

    // Tick periods at two rates.
    measure_period(3'd6, "sel6", n);
    check_int("tick_period_sel6", n, 108);
    measure_period(3'd0, "sel0", n);
    check_int("tick_period_sel0", n, 20833);
    check_int("bit_period_sel0", 16 * n, 333328);
    @(negedge clk);
    baud_select = 3'd7;
    repeat (200) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
